// File: rtl/spi_slave_if_if.sv
// SPI pins plus local rx/tx byte bus for spi_slave_if, with slave (DUT) and master (driver) views.
interface spi_slave_if_if;
  // SPI pins
  logic        cs_n;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  // Local byte bus
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] byte_cnt;
  logic        frame_start;
  logic        frame_end;
  logic        tx_underrun;

  modport slave (
    input  cs_n, sck, mosi, tx_data, tx_valid,
    output miso, miso_oe, rx_data, rx_valid, tx_ready,
           byte_cnt, frame_start, frame_end, tx_underrun
  );

  modport master (
    output cs_n, sck, mosi, tx_data, tx_valid,
    input  miso, miso_oe, rx_data, rx_valid, tx_ready,
           byte_cnt, frame_start, frame_end, tx_underrun
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave: oversamples cs_n/sck/mosi in the system clock domain, deserializes
// MOSI into bytes and serializes local tx bytes onto MISO, full duplex, MSB first.
module spi_slave_if #(
  parameter int unsigned PHASE       = 0,
  parameter int unsigned ACTIVE      = 0,
  parameter logic [7:0]  TX_DEFAULT  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          rst_n,
  spi_slave_if_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic SCK_IDLE = (ACTIVE != 0) ? 1'b1 : 1'b0;
  localparam logic PHASE1   = (PHASE  != 0) ? 1'b1 : 1'b0;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] flush_q,     flush_d;
  logic                   cs_prev_q,   cs_prev_d;
  logic                   sck_prev_q,  sck_prev_d;
  logic                   armed_q,     armed_d;

  // Frame control
  logic [1:0]  state_q,   state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        hold_q,    hold_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;

  // Shift registers
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  tx_sh_q, tx_sh_d;

  // Registered outputs
  logic        miso_q,        miso_d;
  logic        miso_oe_q,     miso_oe_d;
  logic [7:0]  rx_data_q,     rx_data_d;
  logic        rx_valid_q,    rx_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q,   frame_end_d;
  logic        tx_underrun_q, tx_underrun_d;

  // Decoded events
  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic load_now, boundary, byte_done;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Shift the pins through the synchronizers and detect edges against the previous synchronized value
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  bus.sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    // flush marks when the reset preset has fully drained out of the synchronizers
    flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
    cs_prev_d   = cs_s;
    sck_prev_d  = sck_s;
    // a frame may only start after cs_n has genuinely been seen high since reset
    armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);

    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    lead_edge   = (sck_prev_q == SCK_IDLE) && (sck_s != SCK_IDLE);
    trail_edge  = (sck_prev_q != SCK_IDLE) && (sck_s == SCK_IDLE);
    sample_edge = PHASE1 ? trail_edge : lead_edge;
    shift_edge  = PHASE1 ? lead_edge  : trail_edge;
  end

  // Frame FSM: byte assembly, MISO serialization and tx byte loading
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    hold_d        = hold_q;
    byte_cnt_d    = byte_cnt_q;
    rx_sh_d       = rx_sh_q;
    tx_sh_d       = tx_sh_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    tx_underrun_d = 1'b0;
    load_now      = 1'b0;
    boundary      = 1'b0;
    byte_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && cs_fall) begin
          state_d       = ST_LOAD;
          frame_start_d = 1'b1;
          byte_cnt_d    = 16'd0;
          bit_cnt_d     = 3'd0;
        end
      end

      ST_LOAD: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
        end else begin
          load_now = 1'b1;
          state_d  = ST_XFER;
        end
      end

      ST_XFER: begin
        if (sample_edge) begin
          rx_sh_d = {rx_sh_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            byte_done  = 1'b1;
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd0;
            if (byte_cnt_q != 16'hFFFF) begin
              byte_cnt_d = byte_cnt_q + 16'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (shift_edge) begin
          if (hold_q) begin
            // bit7 of a freshly loaded byte: present it without shifting
            miso_d = tx_sh_q[7];
            hold_d = 1'b0;
          end else begin
            miso_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end

        // a completing byte still reports even when cs_n rises in the same cycle
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
        end else if (byte_done) begin
          load_now = 1'b1;
          boundary = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_now) begin
      tx_sh_d       = bus.tx_valid ? bus.tx_data : TX_DEFAULT;
      tx_underrun_d = ~bus.tx_valid;
      miso_d        = tx_sh_d[7];
      // PHASE=1 presents bit7 on the next shift edge; PHASE=0 skips the trailing edge after a boundary
      hold_d        = PHASE1 | boundary;
    end

    miso_oe_d = (state_d != ST_IDLE);
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cs_sync_q     <= {SYNC_STAGES{1'b1}};
      sck_sync_q    <= {SYNC_STAGES{SCK_IDLE}};
      flush_q       <= '0;
      cs_prev_q     <= 1'b1;
      sck_prev_q    <= SCK_IDLE;
      armed_q       <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      hold_q        <= 1'b0;
      byte_cnt_q    <= 16'd0;
      miso_q        <= TX_DEFAULT[7];
      miso_oe_q     <= 1'b0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sck_sync_q    <= sck_sync_d;
      flush_q       <= flush_d;
      cs_prev_q     <= cs_prev_d;
      sck_prev_q    <= sck_prev_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      byte_cnt_q    <= byte_cnt_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // Data-only registers: mosi synchronizer and shift registers carry no reset
  always_ff @(posedge clock) begin
    mosi_sync_q <= mosi_sync_d;
    rx_sh_q     <= rx_sh_d;
    tx_sh_q     <= tx_sh_d;
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_ready    = load_now;
  assign bus.byte_cnt    = byte_cnt_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a mode-0 and a mode-3 instance driven by one SPI master model.
module tb_spi_slave_if;

  localparam int H = 8;   // sck half period in system clocks

  logic clock;
  logic rst_n;

  spi_slave_if_if b0 ();
  spi_slave_if_if b3 ();

  spi_slave_if #(.PHASE(0), .ACTIVE(0), .TX_DEFAULT(8'hFF), .SYNC_STAGES(2))
    u_m0 (.clock(clock), .rst_n(rst_n), .bus(b0));
  spi_slave_if #(.PHASE(1), .ACTIVE(1), .TX_DEFAULT(8'hFF), .SYNC_STAGES(2))
    u_m3 (.clock(clock), .rst_n(rst_n), .bus(b3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Master model pins, routed to whichever instance is selected
  int   cur_mode;
  logic m_cs_n, m_sck, m_mosi, cur_miso;
  assign b0.cs_n  = (cur_mode == 0) ? m_cs_n : 1'b1;
  assign b0.sck   = (cur_mode == 0) ? m_sck  : 1'b0;
  assign b0.mosi  = m_mosi;
  assign b3.cs_n  = (cur_mode == 3) ? m_cs_n : 1'b1;
  assign b3.sck   = (cur_mode == 3) ? m_sck  : 1'b1;
  assign b3.mosi  = m_mosi;
  assign cur_miso = (cur_mode == 0) ? b0.miso : b3.miso;

  logic [7:0] mo [8];
  logic [7:0] mi [8];

  int n_tests = 0;
  int n_fail  = 0;

  // Mode-0 instance monitor
  int         rx0_n = 0, fs0_n = 0, fe0_n = 0, rdy0_n = 0, oe0_n = 0;
  logic [15:0] bcnt0_fe = 16'd0;
  logic [7:0] rxq0 [$];
  int         ur0q [$];
  always @(negedge clock) begin
    if (b0.tx_underrun) ur0q.push_back(rx0_n + (b0.rx_valid ? 1 : 0));
    if (b0.rx_valid) begin
      rxq0.push_back(b0.rx_data);
      rx0_n++;
    end
    if (b0.frame_start) fs0_n++;
    if (b0.frame_end) begin
      fe0_n++;
      bcnt0_fe = b0.byte_cnt;
    end
    if (b0.tx_ready) rdy0_n++;
    if (b0.miso_oe)  oe0_n++;
  end

  // Mode-3 instance monitor
  int         rx3_n = 0;
  logic [7:0] rxq3 [$];
  always @(negedge clock) begin
    if (b3.rx_valid) begin
      rxq3.push_back(b3.rx_data);
      rx3_n++;
    end
  end

  // Mode-3 tx byte source: presents tx_q in order, drops tx_valid when exhausted
  logic [7:0] tx_q [3];
  int         tx_idx = 0;
  int         hs3 = 0;
  initial begin
    tx_q[0] = 8'hA5; tx_q[1] = 8'h3C; tx_q[2] = 8'h81;
    b3.tx_data  = tx_q[0];
    b3.tx_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (b3.tx_valid && b3.tx_ready) begin
        hs3++;
        @(posedge clock);
        #1;
        tx_idx++;
        if (tx_idx < 3) b3.tx_data = tx_q[tx_idx];
        else            b3.tx_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_mode(input int m);
    cur_mode = m;
    m_cs_n   = 1'b1;
    m_sck    = (m == 3);
    wait_clk(10);
  endtask

  // Master frame: nbits bits from mo[], capturing miso into mi[]; optionally leaves cs_n low
  task automatic spi_frame(input int nbits, input bit close, input int gap);
    m_sck  = (cur_mode == 3);
    m_cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      int byi;
      int bi;
      byi = i / 8;
      bi  = 7 - (i % 8);
      if (cur_mode == 0) begin
        m_mosi = mo[byi][bi];
        wait_clk(H);
        mi[byi][bi] = cur_miso;
        m_sck = 1'b1;
        wait_clk(H);
        m_sck = 1'b0;
      end else begin
        m_sck  = 1'b0;
        m_mosi = mo[byi][bi];
        wait_clk(H);
        mi[byi][bi] = cur_miso;
        m_sck = 1'b1;
        wait_clk(H);
      end
    end
    if (close) begin
      wait_clk(H);
      m_cs_n = 1'b1;
      wait_clk(gap);
    end
  endtask

  function automatic logic [63:0] out_vec0();
    return {b0.miso, b0.miso_oe, b0.rx_valid, b0.tx_ready, b0.frame_start,
            b0.frame_end, b0.tx_underrun, b0.rx_data, b0.byte_cnt};
  endfunction

  // Reset view: miso=1 (TX_DEFAULT bit7), everything else 0
  localparam logic [63:0] RST_VEC = {1'b1, 6'd0, 8'd0, 16'd0};

  initial begin
    int rb, fsb, feb, rdb, oeb, ub, cnt;

    cur_mode = 0;
    m_cs_n   = 1'b1;
    m_sck    = 1'b0;
    m_mosi   = 1'b0;
    b0.tx_data  = 8'h00;
    b0.tx_valid = 1'b0;
    rst_n    = 1'b0;
    wait_clk(3);

    // Reset state
    check("rst_outputs_m0", out_vec0(), RST_VEC);
    check("rst_miso_m3", {63'd0, b3.miso}, 64'd1);
    rst_n = 1'b1;
    wait_clk(10);

    // Mode 0, tx idle: five bytes 00..04
    set_mode(0);
    rb = rx0_n; fsb = fs0_n; feb = fe0_n; ub = ur0q.size();
    for (int k = 0; k < 5; k++) mo[k] = 8'(k);
    spi_frame(40, 1'b1, 10);
    check("m0_rx_count", 64'(rx0_n - rb), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("m0_rx_byte%0d", k), 64'(rxq0[rb + k]), 64'(k));
      check($sformatf("m0_miso_byte%0d", k), 64'(mi[k]), 64'hFF);
    end
    check("m0_bytecnt_at_end", 64'(bcnt0_fe), 64'd5);
    check("m0_frame_start", 64'(fs0_n - fsb), 64'd1);
    check("m0_frame_end", 64'(fe0_n - feb), 64'd1);
    // underruns that supplied the five bytes actually shifted out
    cnt = 0;
    for (int k = ub; k < ur0q.size(); k++) begin
      if ((ur0q[k] - rb) >= 0 && (ur0q[k] - rb) < 5) cnt++;
    end
    check("m0_underruns", 64'(cnt), 64'd5);

    // Mode 3, tx supplies A5 3C 81
    set_mode(3);
    rb = rx3_n;
    mo[0] = 8'h5A; mo[1] = 8'hC3; mo[2] = 8'h7E;
    spi_frame(24, 1'b1, 10);
    check("m3_miso_byte0", 64'(mi[0]), 64'hA5);
    check("m3_miso_byte1", 64'(mi[1]), 64'h3C);
    check("m3_miso_byte2", 64'(mi[2]), 64'h81);
    check("m3_tx_handshakes", 64'(hs3), 64'd3);
    check("m3_rx_count", 64'(rx3_n - rb), 64'd3);
    check("m3_rx_byte0", 64'(rxq3[rb]), 64'h5A);
    check("m3_rx_byte2", 64'(rxq3[rb + 2]), 64'h7E);

    // cs_n rises after 5 bits of the second byte
    set_mode(0);
    rb = rx0_n; feb = fe0_n;
    mo[0] = 8'h12; mo[1] = 8'h34;
    spi_frame(13, 1'b1, 10);
    check("abort_rx_count", 64'(rx0_n - rb), 64'd1);
    check("abort_rx_byte", 64'(rxq0[rb]), 64'h12);
    check("abort_frame_end", 64'(fe0_n - feb), 64'd1);
    check("abort_bytecnt", 64'(bcnt0_fe), 64'd1);

    // Reset for one clock mid-byte, then a clean frame of 55
    mo[0] = 8'hC7;
    spi_frame(3, 1'b0, 0);
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst_outputs", out_vec0(), RST_VEC);
    rst_n  = 1'b1;
    m_cs_n = 1'b1;
    m_sck  = 1'b0;
    wait_clk(10);
    rb = rx0_n;
    mo[0] = 8'h55;
    spi_frame(8, 1'b1, 10);
    check("midrst_rx_count", 64'(rx0_n - rb), 64'd1);
    check("midrst_rx_byte", 64'(rxq0[rb]), 64'h55);

    // sck toggling with cs_n high
    rb = rx0_n; rdb = rdy0_n; oeb = oe0_n;
    m_cs_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      m_sck = ~m_sck;
      wait_clk(H);
    end
    m_sck = 1'b0;
    wait_clk(10);
    check("idle_sck_rx", 64'(rx0_n - rb), 64'd0);
    check("idle_sck_ready", 64'(rdy0_n - rdb), 64'd0);
    check("idle_sck_oe", 64'(oe0_n - oeb), 64'd0);

    // Four back-to-back one-byte frames at minimum cs_n gap
    rb = rx0_n; fsb = fs0_n; feb = fe0_n;
    for (int f = 0; f < 4; f++) begin
      mo[0] = 8'(f + 1);
      spi_frame(8, 1'b1, 4);
    end
    wait_clk(10);
    check("b2b_frame_start", 64'(fs0_n - fsb), 64'd4);
    check("b2b_frame_end", 64'(fe0_n - feb), 64'd4);
    check("b2b_rx_count", 64'(rx0_n - rb), 64'd4);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("b2b_rx_byte%0d", f), 64'(rxq0[rb + f]), 64'(f + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
